// File: rtl/spram_arbiter_pkg.sv
// Shared definitions for the single-port SRAM arbiter.
//   clog2   : ceiling log2 used to size address and requester-index fields
//   state_t : controller states (ST_IDLE serves requests, ST_CLEAR zero-fills)
package spram_arbiter_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      res++;
      rem = rem >> 1;
    end
    return res;
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection.
//   req   : per-requester request vector
//   ptr   : requester index where the priority search starts
//   grant : one-hot grant (zero when no request)
//   idx   : encoded index of the granted requester (0 when no request)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  always_comb begin
    logic        found;
    int unsigned j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Multi-requester front end for one single-port SRAM, with a bulk zero-fill.
//   clk, rst         : clock, synchronous active-high reset
//   clr_start        : pulse to start zeroing the whole memory
//   clr_busy/done    : clear in progress / one-cycle completion pulse
//   req_*            : per-requester valid/we/addr/wdata (flattened), req_ready grant
//   rsp_*            : read response, two cycles after the read grant
//   sram_*           : registered SRAM controls (active-low cen/wen), sram_q read data
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned AW        = clog2(MEM_DEPTH),
  parameter int unsigned IW        = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_start,
  output logic                         clr_busy,
  output logic                         clr_done,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*AW-1:0]        req_addr,
  input  logic [NUM_REQ*MEM_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [IW-1:0]                rsp_id,
  output logic [MEM_WIDTH-1:0]         rsp_data,
  output logic                         sram_cen,
  output logic                         sram_wen,
  output logic [AW-1:0]                sram_addr,
  output logic [MEM_WIDTH-1:0]         sram_d,
  input  logic [MEM_WIDTH-1:0]         sram_q
);

  state_t                 state, state_nx;
  logic [IW-1:0]          ptr;
  logic [AW-1:0]          clr_cnt;
  logic                   clr_last;
  logic [NUM_REQ-1:0]     grant;
  logic [IW-1:0]          gnt_idx;
  logic                   xfer;
  logic                   sel_we;
  logic [AW-1:0]          sel_addr;
  logic [MEM_WIDTH-1:0]   sel_wdata;
  logic                   p1_valid;
  logic [IW-1:0]          p1_id;
  logic                   done_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign clr_last = (clr_cnt == AW'(MEM_DEPTH - 1));

  // Grants only in IDLE; a clear request in the same cycle pre-empts the grant.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      ST_IDLE: begin
        if (clr_start) state_nx = ST_CLEAR;
        else           req_ready = grant;
      end
      ST_CLEAR: begin
        if (clr_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  assign xfer     = |req_ready;
  assign clr_busy = (state == ST_CLEAR);
  assign clr_done = done_q;
  // sram_q already carries the word for the access issued one cycle earlier.
  assign rsp_data = sram_q;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*MEM_WIDTH +: MEM_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      clr_cnt   <= '0;
      done_q    <= 1'b0;
      p1_valid  <= 1'b0;
      p1_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_addr <= '0;
      sram_d    <= '0;
    end else begin
      done_q    <= (state == ST_CLEAR) && clr_last;
      p1_valid  <= xfer && !sel_we;
      p1_id     <= gnt_idx;
      rsp_valid <= p1_valid;
      rsp_id    <= p1_id;

      if (xfer) ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

      if (state == ST_CLEAR) begin
        clr_cnt   <= clr_last ? '0 : clr_cnt + 1'b1;
        sram_cen  <= 1'b0;
        sram_wen  <= 1'b0;
        sram_addr <= clr_cnt;
        sram_d    <= '0;
      end else if (xfer) begin
        sram_cen  <= 1'b0;
        sram_wen  <= !sel_we;
        sram_addr <= sel_addr;
        sram_d    <= sel_wdata;
      end else begin
        sram_cen  <= 1'b1;
        sram_wen  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter with a behavioural SRAM attached.
module tb_spram_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr_start;
  logic            clr_busy, clr_done;
  logic [N-1:0]    req_valid, req_we, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_wdata;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_data;
  logic            sram_cen, sram_wen;
  logic [AW-1:0]   sram_addr;
  logic [W-1:0]    sram_d, sram_q;

  always #5 clk = ~clk;

  spram_arbiter #(
    .MEM_WIDTH (W),
    .MEM_DEPTH (D),
    .NUM_REQ   (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  // Behavioural single-port SRAM: read data appears the cycle after the access.
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= sram_d;
      else           sram_q <= mem[sram_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           m_ptr, m_clr_addr, cyc;
  bit           m_clearing, m_done, m_cen, m_wen;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_d;
  logic [W-1:0]  ref_mem [D];
  bit            ev_v  [int];
  int            ev_id [int];
  logic [W-1:0]  ev_d  [int];
  logic [N-1:0]  granted_last;

  // Observations from the latest step
  logic [N-1:0] o_ready;
  logic         o_rsp_valid, o_busy, o_done, o_cen, o_wen;
  logic [IW-1:0] o_rsp_id;
  logic [W-1:0] o_rsp_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (rst || m_clearing || clr_start) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  // One clock cycle: check outputs mid-cycle, advance the model, cross the edge.
  task automatic step();
    int g;
    logic [N-1:0] exp_ready;
    logic [AW-1:0] a;
    @(negedge clk);
    g = exp_grant();
    exp_ready = (g >= 0) ? N'(1) << g : '0;
    o_ready = req_ready; o_rsp_valid = rsp_valid; o_rsp_id = rsp_id; o_rsp_data = rsp_data;
    o_busy = clr_busy; o_done = clr_done; o_cen = sram_cen; o_wen = sram_wen;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("clr_busy", 64'(clr_busy), 64'(m_clearing));
    chk("clr_done", 64'(clr_done), 64'(m_done));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev_v.exists(cyc)));
    if (ev_v.exists(cyc)) begin
      chk("rsp_id", 64'(rsp_id), 64'(ev_id[cyc]));
      chk("rsp_data", 64'(rsp_data), 64'(ev_d[cyc]));
    end
    chk("sram_cen", 64'(sram_cen), 64'(m_cen));
    chk("sram_wen", 64'(sram_wen), 64'(m_wen));
    chk("sram_addr", 64'(sram_addr), 64'(m_addr));
    chk("sram_d", 64'(sram_d), 64'(m_d));

    granted_last = exp_ready;
    if (rst) begin
      m_ptr = 0; m_clearing = 0; m_clr_addr = 0; m_done = 0;
      m_cen = 1; m_wen = 1; m_addr = '0; m_d = '0;
      ev_v.delete(); ev_id.delete(); ev_d.delete();
    end else begin
      m_done = 0;
      if (m_clearing) begin
        m_cen = 0; m_wen = 0; m_addr = AW'(m_clr_addr); m_d = '0;
        ref_mem[m_clr_addr] = '0;
        if (m_clr_addr == D - 1) begin
          m_clearing = 0; m_done = 1; m_clr_addr = 0;
        end else m_clr_addr++;
      end else if (clr_start) begin
        m_clearing = 1; m_cen = 1; m_wen = 1;
      end else if (g >= 0) begin
        m_ptr = (g + 1) % N;
        a = req_addr[g*AW +: AW];
        m_cen = 0; m_wen = !req_we[g]; m_addr = a; m_d = req_wdata[g*W +: W];
        if (req_we[g]) ref_mem[a] = m_d;
        else begin
          ev_v[cyc+2] = 1; ev_id[cyc+2] = g; ev_d[cyc+2] = ref_mem[a];
        end
      end else begin
        m_cen = 1; m_wen = 1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input int addr, input logic [W-1:0] d);
    req_valid[i] = v;
    req_we[i] = we;
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*W +: W] = d;
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || granted_last[i])
        set_req(i, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, D - 1)), $urandom);
    end
  endtask

  initial begin
    int busy_cnt, wr_cnt, done_cnt, rsp_cnt, nz_cnt;
    for (int i = 0; i < D; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    rst = 1; clr_start = 0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    granted_last = '0; cyc = 0;
    m_ptr = 0; m_clearing = 0; m_clr_addr = 0; m_done = 0;
    m_cen = 1; m_wen = 1; m_addr = '0; m_d = '0;
    @(posedge clk); #1;
    step();
    rst = 0;

    // Write then read-back through a different requester
    set_req(0, 1, 1, 5, 32'hDEADBEEF);
    step();
    chk("wr_grant", 64'(o_ready), 64'h1);
    set_req(0, 0, 0, 0, '0);
    set_req(2, 1, 0, 5, '0);
    step();
    chk("rd_grant", 64'(o_ready), 64'h4);
    set_req(2, 0, 0, 0, '0);
    step();
    step();
    chk("rd_rsp_valid", 64'(o_rsp_valid), 64'h1);
    chk("rd_rsp_id", 64'(o_rsp_id), 64'h2);
    chk("rd_rsp_data", 64'(o_rsp_data), 64'hDEADBEEF);

    // All requesters reading continuously from a fresh pointer
    rst = 1; step(); rst = 0;
    for (int i = 0; i < N; i++) set_req(i, 1, 0, i + 8, '0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rr_grant", 64'(o_ready), 64'(1) << (k % 4));
      if (k >= 2) begin
        chk("rr_rsp_valid", 64'(o_rsp_valid), 64'h1);
        chk("rr_rsp_id", 64'(o_rsp_id), 64'((k - 2) % 4));
      end
    end
    req_valid = '0;
    step(); step();

    // Clear racing a request in the same cycle
    clr_start = 1;
    set_req(1, 1, 0, 7, '0);
    step();
    chk("clr_race_ready", 64'(o_ready), 64'h0);
    clr_start = 0;
    busy_cnt = 0; wr_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_busy) busy_cnt++;
      if (!o_cen && !o_wen) wr_cnt++;
      if (o_done) begin
        done_cnt++;
        chk("grant_after_clear", 64'(o_ready), 64'h2);
      end
      if (o_busy) chk("ready_in_clear", 64'(o_ready), 64'h0);
      if (o_ready[1]) req_valid[1] = 0;
    end
    chk("clr_busy_cycles", 64'(busy_cnt), 64'(D));
    chk("clr_writes", 64'(wr_cnt), 64'(D));
    chk("clr_done_pulses", 64'(done_cnt), 64'h1);
    step(); step();

    // Every address reads back zero
    rsp_cnt = 0; nz_cnt = 0;
    for (int a = 0; a < D + 2; a++) begin
      if (a < D) set_req(0, 1, 0, a, '0);
      else       req_valid[0] = 0;
      step();
      if (o_rsp_valid) begin
        rsp_cnt++;
        if (o_rsp_data != '0) nz_cnt++;
      end
    end
    chk("clr_readback_count", 64'(rsp_cnt), 64'(D));
    chk("clr_readback_nonzero", 64'(nz_cnt), 64'h0);

    // Reset right after a read grant drops the response
    set_req(0, 1, 0, 5, '0);
    step();
    chk("pre_rst_grant", 64'(o_ready), 64'h1);
    req_valid = '0;
    rst = 1; step(); rst = 0;
    rsp_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (o_rsp_valid) rsp_cnt++;
    end
    chk("rsp_after_rst", 64'(rsp_cnt), 64'h0);
    chk("rst_cen", 64'(o_cen), 64'h1);
    chk("rst_busy", 64'(o_busy), 64'h0);
    for (int i = 0; i < N; i++) set_req(i, 1, 0, i, '0);
    step();
    chk("ptr_after_rst", 64'(o_ready), 64'h1);
    req_valid = '0;
    step(); step();

    // Idle with no requests
    for (int k = 0; k < 6; k++) begin
      step();
      chk("idle_cen", 64'(o_cen), 64'h1);
      chk("idle_wen", 64'(o_wen), 64'h1);
    end

    // Second clr_start while clearing is ignored
    clr_start = 1;
    step();
    busy_cnt = 0; wr_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      clr_start = (k == 5);
      step();
      if (o_busy) busy_cnt++;
      if (!o_cen && !o_wen) wr_cnt++;
      if (o_done) done_cnt++;
    end
    clr_start = 0;
    chk("reclr_busy_cycles", 64'(busy_cnt), 64'(D));
    chk("reclr_writes", 64'(wr_cnt), 64'(D));
    chk("reclr_done_pulses", 64'(done_cnt), 64'h1);

    // Randomised traffic with occasional clears and resets
    for (int k = 0; k < 400; k++) begin
      rand_reqs();
      clr_start = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 0; clr_start = 0; req_valid = '0;
    for (int k = 0; k < 20; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- MEM_WIDTH, 32, data width.
- MEM_DEPTH, 4096, words.
- NUM_REQ, 4, requester count.
- AW = clog2(MEM_DEPTH), derived address width.
REQ-002 The block SHALL have one clock and a synchronous active-high reset. Ports (clock and reset first):
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- clr_start  in  1  pulse, start memory clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse at clear end.
- req_valid  in  NUM_REQ  per-requester request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*AW  flattened, requester i at [i*AW +: AW].
- req_wdata  in  NUM_REQ*MEM_WIDTH  flattened, same packing.
- req_ready  out  NUM_REQ  grant, one-hot or zero.
- rsp_valid  out  1  read data valid.
- rsp_id  out  clog2(NUM_REQ)  requester index of the response.
- rsp_data  out  MEM_WIDTH  read data.
- sram_cen  out  1  SRAM chip enable, active low, registered.
- sram_wen  out  1  SRAM write enable, active low, registered.
- sram_addr  out  AW  registered.
- sram_d  out  MEM_WIDTH  registered.
- sram_q  in  MEM_WIDTH  SRAM read data, valid one cycle after the access cycle.

Function
REQ-003 The block SHALL grant at most one request per cycle; a transfer occurs when req_valid[i] && req_ready[i].
REQ-004 req_ready SHALL be combinational from req_valid, the round-robin pointer and FSM state. Only state IDLE SHALL grant. Requests SHALL be held until granted.
REQ-005 Arbitration SHALL be round-robin: search starts at pointer ptr. On a grant to i, ptr becomes (i+1) mod NUM_REQ. ptr SHALL NOT change on cycles with no grant.
REQ-006 A transfer accepted in cycle t SHALL drive, during cycle t+1:
- sram_cen=0
- sram_wen=~req_we[i]
- sram_addr=req_addr[i]
- sram_d=req_wdata[i]
REQ-007 In cycles with no access, the SRAM outputs SHALL be:
- sram_cen=1 and sram_wen=1.
- sram_addr and sram_d holding their last values.
REQ-008 A read accepted in cycle t SHALL produce rsp_valid=1, rsp_id=i and rsp_data=sram_q in cycle t+2. Writes SHALL produce no response.
REQ-009 Accesses SHALL reach the SRAM in grant order. A write to address A followed by a read of A in any later cycle SHALL return the written data.
REQ-010 The FSM SHALL have states IDLE and CLEAR:
- IDLE -> CLEAR on clr_start.
- CLEAR -> IDLE after the write to address MEM_DEPTH-1 is issued.
REQ-011 In CLEAR, the block SHALL write 0 to addresses 0..MEM_DEPTH-1, one per cycle, using an AW-bit counter. clr_busy=1 throughout CLEAR.
REQ-012 clr_done SHALL pulse for one cycle in the cycle the FSM returns to IDLE. Requests pending during CLEAR SHALL be granted from the next cycle.
REQ-013 If clr_start and req_valid are asserted in the same IDLE cycle, the clear SHALL win and no grant SHALL be issued that cycle.
REQ-014 clr_start SHALL be ignored while in CLEAR.
REQ-015 A read accepted in the cycle before CLEAR is entered SHALL still return its response at t+2.
REQ-016 The clear counter SHALL NOT wrap into a second pass; the terminal count is MEM_DEPTH-1 for non-power-of-two depths.

Reset
REQ-017 When rst=1 at a clock edge, the following SHALL result:
- state=IDLE, ptr=0, clear counter=0.
- sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0.
- rsp_valid=0, rsp_id=0, clr_busy=0, clr_done=0.
- Read-pipeline valid bits cleared.
REQ-018 Reset mid-operation SHALL abort the clear (memory partially cleared) and drop all in-flight read responses; no rsp_valid SHALL appear in the cycles after reset.
REQ-019 req_ready SHALL be 0 in any cycle with rst=1.

Structure
REQ-020 A shared package/header SHALL hold the clog2 function and the FSM state encodings (ST_IDLE, ST_CLEAR).
REQ-021 The round-robin grant logic SHALL be one sub-module, rr_arbiter: inputs req and ptr, outputs one-hot grant and encoded index.
REQ-022 The block SHALL be synthesizable and SHALL NOT instantiate the SRAM; the SRAM is connected at the parent level.

Verification
REQ-023 The bench SHALL cover the following directed scenarios, with a behavioural SRAM model attached:
- Write from requester 0 to addr 5 with data 0xDEADBEEF, then read from requester 2 at addr 5 -> rsp_valid two cycles after the read grant, rsp_id=2, rsp_data=0xDEADBEEF.
- All four requesters hold valid reads continuously -> grants 0,1,2,3,0,… one per cycle; rsp_id follows the same order with 2-cycle latency.
- clr_start and req_valid[1] in the same cycle with MEM_DEPTH=16 -> clr_busy high for 16 cycles, req_ready=0 throughout, clr_done pulses once, req1 granted the next cycle, reads of every address return 0.
- Read granted, then rst asserted the next cycle -> no rsp_valid; all outputs at reset values; ptr=0.
- Idle with no requests -> sram_cen=1 and sram_wen=1 every cycle; sram_addr/sram_d unchanged.
- clr_start pulsed again mid-clear -> ignored; exactly MEM_DEPTH clear writes and one clr_done.
